// File: rtl/timer_arbiter.sv
// Round-robin owner of a shared flex counter: grants one of two requesters, times its
// interval on the external counter, then pulses that requester's done strobe.
module timer_arbiter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_i,
   input  logic             req1_i,
   input  logic [Width-1:0] val0_i,
   input  logic [Width-1:0] val1_i,
   output logic             gnt0_o,
   output logic             gnt1_o,
   output logic             done0_o,
   output logic             done1_o,
   output logic             busy_o,
   output logic             clear_o,
   output logic             count_enable_o,
   output logic [Width-1:0] rollover_val_o,
   input  logic             rollover_flag_i
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [Width-1:0] interval_q, interval_d;
   logic             owner_req;
   logic             win1;

   // last_q doubles as the current owner while busy
   assign owner_req = last_q ? req1_i : req0_i;
   assign win1      = req1_i & (~req0_i | ~last_q);

   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      interval_d     = interval_q;
      clear_o        = 1'b0;
      count_enable_o = 1'b0;
      done0_o        = 1'b0;
      done1_o        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req0_i || req1_i) begin
               last_d     = win1;
               interval_d = win1 ? val1_i : val0_i;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            clear_o = 1'b1;
            if (!owner_req) begin
               state_d = StIdle;
            end else if (interval_q == '0) begin
               state_d = StDone;
            end else begin
               state_d = StRun;
            end
         end
         StRun: begin
            count_enable_o = ~rollover_flag_i;
            if (!owner_req) begin
               clear_o = 1'b1;
               state_d = StIdle;
            end else if (rollover_flag_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            clear_o = 1'b1;
            done0_o = ~last_q;
            done1_o = last_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         interval_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         interval_q <= interval_d;
      end
   end

   assign busy_o         = (state_q != StIdle);
   assign gnt0_o         = busy_o & ~last_q;
   assign gnt1_o         = busy_o & last_q;
   assign rollover_val_o = interval_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: behavioural flex counter plus a scoreboard of expected
// done strobes (requester id and cycle).
module tb_timer_arbiter;

   localparam int unsigned Width = 4;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             req0_i = 1'b0, req1_i = 1'b0;
   logic [Width-1:0] val0_i = '0, val1_i = '0;
   logic             gnt0_o, gnt1_o, done0_o, done1_o, busy_o, clear_o, count_enable_o;
   logic [Width-1:0] rollover_val_o;
   logic             rollover_flag_i;
   logic [Width-1:0] cnt_q;

   typedef struct {
      int id;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   timer_arbiter #(.Width(Width)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req0_i         (req0_i),
      .req1_i         (req1_i),
      .val0_i         (val0_i),
      .val1_i         (val1_i),
      .gnt0_o         (gnt0_o),
      .gnt1_o         (gnt1_o),
      .done0_o        (done0_o),
      .done1_o        (done1_o),
      .busy_o         (busy_o),
      .clear_o        (clear_o),
      .count_enable_o (count_enable_o),
      .rollover_val_o (rollover_val_o),
      .rollover_flag_i(rollover_flag_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Flex counter model
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else if (clear_o) cnt_q <= '0;
      else if (count_enable_o) cnt_q <= cnt_q + 1'b1;
   end
   assign rollover_flag_i = (cnt_q == rollover_val_o);

   // Done monitor / scoreboard pop
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (gnt0_o || gnt1_o) begin
            checks++;
            if (gnt0_o && gnt1_o) begin
               errors++;
               $display("FAIL gnt_mutex cyc=%0d gnt0=%b gnt1=%b required not both", cyc,
                        gnt0_o, gnt1_o);
            end
         end
         if (done0_o || done1_o) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected cyc=%0d done0=%b done1=%b required none", cyc,
                        done0_o, done1_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ((done0_o && done1_o) || (done1_o ? 1 : 0) !== e.id || cyc !== e.cyc ||
                   (done0_o && !gnt0_o) || (done1_o && !gnt1_o)) begin
                  errors++;
                  $display("FAIL done_event got id=%0d cyc=%0d gnt0=%b gnt1=%b required id=%0d cyc=%0d",
                           done1_o ? 1 : 0, cyc, gnt0_o, gnt1_o, e.id, e.cyc);
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst_i = 1'b1;
      #2;
      checks++;
      if ({gnt0_o, gnt1_o, done0_o, done1_o, busy_o, clear_o, count_enable_o} !== 7'b0 ||
          rollover_val_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b/%0d required 0000000/0",
                  {gnt0_o, gnt1_o, done0_o, done1_o, busy_o, clear_o, count_enable_o},
                  rollover_val_o);
      end
      @(negedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0 || gnt0_o !== 1'b0 || clear_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b gnt0=%b clear=%b required 0 0 0", busy_o, gnt0_o,
                  clear_o);
      end
   endtask

   task automatic test_single();
      int t;
      int ce;
      ce = 0;
      @(negedge clk_i);
      #1;
      t = cyc;
      req0_i = 1'b1;
      val0_i = 4'd3;
      sb.push_back('{id: 0, cyc: t + 6});
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk_i);
         if (count_enable_o) ce++;
         checks++;
         if (busy_o !== gnt0_o) begin
            errors++;
            $display("FAIL single_busy k=%0d got busy=%b required %b", k, busy_o, gnt0_o);
         end
         if (k == 1) begin
            checks++;
            if (gnt0_o !== 1'b1) begin
               errors++;
               $display("FAIL single_gnt_rise got %b required 1", gnt0_o);
            end
         end
         if (k == 7) begin
            checks++;
            if (gnt0_o !== 1'b0) begin
               errors++;
               $display("FAIL single_gnt_fall got %b required 0", gnt0_o);
            end
         end
         if (k == 6) begin
            #1 req0_i = 1'b0;
         end
      end
      checks++;
      if (ce !== 3) begin
         errors++;
         $display("FAIL single_enable_cycles got %0d required 3", ce);
      end
   endtask

   task automatic test_contention();
      int t;
      @(negedge clk_i);
      #1 rst_i = 1'b1;
      @(negedge clk_i);
      #1;
      rst_i  = 1'b0;
      t      = cyc;
      req0_i = 1'b1;
      req1_i = 1'b1;
      val0_i = 4'd2;
      val1_i = 4'd4;
      sb.push_back('{id: 0, cyc: t + 5});
      sb.push_back('{id: 1, cyc: t + 13});
      sb.push_back('{id: 0, cyc: t + 19});
      sb.push_back('{id: 1, cyc: t + 27});
      for (int k = 1; k <= 28; k++) begin
         @(negedge clk_i);
         if (k == 1 || k == 7 || k == 15 || k == 21) begin
            logic exp1;
            exp1 = (k == 7 || k == 21);
            checks++;
            if (gnt0_o !== ~exp1 || gnt1_o !== exp1) begin
               errors++;
               $display("FAIL rr_grant k=%0d got gnt0=%b gnt1=%b required gnt1=%b", k, gnt0_o,
                        gnt1_o, exp1);
            end
         end
         if (k == 27) begin
            #1;
            req0_i = 1'b0;
            req1_i = 1'b0;
         end
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rr_idle got busy=%b required 0", busy_o);
      end
   endtask

   task automatic test_zero_interval();
      int t;
      @(negedge clk_i);
      #1;
      t      = cyc;
      req1_i = 1'b1;
      val1_i = 4'd0;
      sb.push_back('{id: 1, cyc: t + 2});
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk_i);
         checks++;
         if (count_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_enable k=%0d got %b required 0", k, count_enable_o);
         end
         if (k == 1) begin
            checks++;
            if (gnt1_o !== 1'b1) begin
               errors++;
               $display("FAIL zero_gnt got %b required 1", gnt1_o);
            end
         end
         if (k == 2) begin
            #1 req1_i = 1'b0;
         end
      end
   endtask

   task automatic test_abort();
      int t;
      @(negedge clk_i);
      #1;
      t      = cyc;
      req0_i = 1'b1;
      val0_i = 4'd10;
      sb.push_back('{id: 1, cyc: t + 10});
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk_i);
         if (k == 1) begin
            #1;
            req1_i = 1'b1;
            val1_i = 4'd1;
         end
         if (k == 5) begin
            #1 req0_i = 1'b0;
            #1;
            checks++;
            if (clear_o !== 1'b1) begin
               errors++;
               $display("FAIL abort_clear got %b required 1", clear_o);
            end
         end
         if (k == 6) begin
            checks++;
            if (busy_o !== 1'b0 || clear_o !== 1'b0) begin
               errors++;
               $display("FAIL abort_idle got busy=%b clear=%b required 0 0", busy_o, clear_o);
            end
         end
         if (k == 7) begin
            checks++;
            if (gnt1_o !== 1'b1 || gnt0_o !== 1'b0) begin
               errors++;
               $display("FAIL abort_next_grant got gnt0=%b gnt1=%b required 0 1", gnt0_o, gnt1_o);
            end
         end
         if (k == 10) begin
            #1 req1_i = 1'b0;
         end
      end
   endtask

   task automatic test_val_stability();
      int t;
      @(negedge clk_i);
      #1;
      t      = cyc;
      req0_i = 1'b1;
      val0_i = 4'd3;
      sb.push_back('{id: 0, cyc: t + 6});
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk_i);
         if (k >= 3 && k <= 5) begin
            checks++;
            if (rollover_val_o !== 4'd3) begin
               errors++;
               $display("FAIL val_hold k=%0d got %0d required 3", k, rollover_val_o);
            end
         end
         if (k == 3) begin
            #1 val0_i = 4'd9;
         end
         if (k == 6) begin
            #1 req0_i = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset();
      int t;
      @(negedge clk_i);
      #1;
      req0_i = 1'b1;
      val0_i = 4'd5;
      for (int k = 1; k <= 3; k++) @(negedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      checks++;
      if ({gnt0_o, gnt1_o, busy_o, count_enable_o, clear_o, done0_o} !== 6'b0 ||
          rollover_val_o !== '0) begin
         errors++;
         $display("FAIL async_reset got %b/%0d required 000000/0",
                  {gnt0_o, gnt1_o, busy_o, count_enable_o, clear_o, done0_o}, rollover_val_o);
      end
      req1_i = 1'b1;
      val1_i = 4'd2;
      #1;
      t     = cyc;
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (cyc !== t + 1 || gnt0_o !== 1'b1 || gnt1_o !== 1'b0) begin
         errors++;
         $display("FAIL async_rr_first got gnt0=%b gnt1=%b required 1 0", gnt0_o, gnt1_o);
      end
      #1;
      req0_i = 1'b0;
      req1_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL async_abort_idle got busy=%b required 0", busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_zero_interval();
      test_abort();
      test_val_stability();
      test_async_reset();
      repeat (3) @(negedge clk_i);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL done_missing got %0d outstanding required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
